// File: rtl/stream_sink_chk.sv
// Consumer for the 32-bit valid/ready stream: programmable backpressure, sequence and handshake checking,
// debug counters. Optional idle-timeout detector is built only when SINK_TIMEOUT_EN is defined.
module stream_sink_chk #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] START_VAL   = '0,
    parameter int               TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_b,
    input  logic             vld_b,
    output logic             rdy_b,
    input  logic [1:0]       cfg_mode,
    input  logic [3:0]       cfg_on,
    input  logic [3:0]       cfg_off,
    output logic [31:0]      beat_cnt,
    output logic [15:0]      err_cnt,
    output logic             err_flag,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_got,
    output logic             proto_err,
    output logic             timeout
);

    typedef enum logic {PER_ON, PER_OFF} per_state_t;

    per_state_t       per_state, per_state_next;
    logic [3:0]       per_cnt, per_cnt_next;
    logic [4:0]       per_cnt_inc;
    logic [4:0]       on_len;
    logic             per_rdy;
    logic             rdy_next;
    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic [WIDTH-1:0] exp_val;
    logic             stall_q;
    logic [WIDTH-1:0] stall_data;
    logic             accept;
    logic             mismatch;
    logic             proto_viol;

    assign accept      = vld_b & rdy_b;
    assign mismatch    = (data_b != exp_val);
    assign proto_viol  = stall_q & (~vld_b | (data_b != stall_data));
    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign on_len      = (cfg_on == 4'd0) ? 5'd1 : {1'b0, cfg_on};
    assign per_cnt_inc = {1'b0, per_cnt} + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_state <= PER_ON;
            per_cnt   <= 4'd0;
        end else begin
            per_state <= per_state_next;
            per_cnt   <= per_cnt_next;
        end
    end

    // Held at ON/0 outside mode 2, so every entry into mode 2 restarts the pattern.
    always_comb begin
        per_state_next = per_state;
        per_cnt_next   = per_cnt;
        per_rdy        = 1'b1;
        if (cfg_mode != 2'd2) begin
            per_state_next = PER_ON;
            per_cnt_next   = 4'd0;
        end else begin
            case (per_state)
                PER_ON: begin
                    per_rdy = 1'b1;
                    if (per_cnt_inc >= on_len) begin
                        per_cnt_next = 4'd0;
                        if (cfg_off != 4'd0) per_state_next = PER_OFF;
                    end else begin
                        per_cnt_next = per_cnt_inc[3:0];
                    end
                end
                PER_OFF: begin
                    per_rdy = 1'b0;
                    if (per_cnt_inc >= {1'b0, cfg_off}) begin
                        per_cnt_next   = 4'd0;
                        per_state_next = PER_ON;
                    end else begin
                        per_cnt_next = per_cnt_inc[3:0];
                    end
                end
                default: begin
                    per_state_next = PER_ON;
                    per_cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        case (cfg_mode)
            2'd0:    rdy_next = 1'b1;
            2'd1:    rdy_next = 1'b0;
            2'd2:    rdy_next = per_rdy;
            default: rdy_next = lfsr[0];
        endcase
    end

    // The LFSR free-runs in every mode; only mode 3 looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_b <= 1'b0;
            lfsr  <= 16'hACE1;
        end else begin
            rdy_b <= rdy_next;
            lfsr  <= {lfsr[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 32'd0;
            err_cnt  <= 16'd0;
            err_flag <= 1'b0;
            err_exp  <= '0;
            err_got  <= '0;
            exp_val  <= START_VAL;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (mismatch) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                err_flag <= 1'b1;
                if (!err_flag) begin
                    err_exp <= exp_val;
                    err_got <= data_b;
                end
            end
            exp_val <= data_b + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q    <= 1'b0;
            stall_data <= '0;
            proto_err  <= 1'b0;
        end else begin
            stall_q    <= vld_b & ~rdy_b;
            stall_data <= data_b;
            if (proto_viol) proto_err <= 1'b1;
        end
    end

`ifdef SINK_TIMEOUT_EN
    logic        started;
    logic [15:0] idle_cnt;
    logic        timeout_q;

    // Idle cycles only count once the stream has delivered its first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started   <= 1'b0;
            idle_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) started <= 1'b1;
            if (vld_b) begin
                idle_cnt <= 16'd0;
            end else if (started && rdy_b && (idle_cnt != 16'hFFFF)) begin
                idle_cnt <= idle_cnt + 16'd1;
                if ((int'(idle_cnt) + 1) >= TIMEOUT_CYC) timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink_chk.sv
// Bench for stream_sink_chk: spec-level reference model checked every cycle plus directed literal checks.
module tb_stream_sink_chk;

    localparam int TO_CYC = 16;
`ifdef SINK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] data_b   = 32'd0;
    logic        vld_b    = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [3:0]  cfg_on   = 4'd0;
    logic [3:0]  cfg_off  = 4'd0;
    logic        rdy_b;
    logic [31:0] beat_cnt;
    logic [15:0] err_cnt;
    logic        err_flag;
    logic [31:0] err_exp;
    logic [31:0] err_got;
    logic        proto_err;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_sink_chk #(.WIDTH(32), .START_VAL(32'd0), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .data_b(data_b), .vld_b(vld_b), .rdy_b(rdy_b),
        .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .beat_cnt(beat_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .err_exp(err_exp), .err_got(err_got), .proto_err(proto_err), .timeout(timeout)
    );

    // Reference model state
    logic        m_rdy;
    logic [15:0] m_lfsr;
    int          m_per_k;
    logic [31:0] m_exp, m_beat, m_eexp, m_egot, m_sdata;
    int          m_errs, m_idle;
    logic        m_flag, m_stall, m_proto, m_started, m_timeout, m_acc;
    int          m_on_eff, m_period;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_rdy = 1'b0; m_lfsr = 16'hACE1; m_per_k = 0;
            m_exp = 32'd0; m_beat = 32'd0; m_eexp = 32'd0; m_egot = 32'd0; m_sdata = 32'd0;
            m_errs = 0; m_idle = 0;
            m_flag = 1'b0; m_stall = 1'b0; m_proto = 1'b0; m_started = 1'b0; m_timeout = 1'b0;
        end else begin
            m_acc = vld_b && m_rdy;
            if (m_stall && (!vld_b || data_b != m_sdata)) m_proto = 1'b1;
            m_stall = vld_b && !m_rdy;
            m_sdata = data_b;
            if (m_acc) begin
                m_beat = m_beat + 32'd1;
                if (data_b != m_exp) begin
                    if (m_errs < 65535) m_errs = m_errs + 1;
                    if (!m_flag) begin m_eexp = m_exp; m_egot = data_b; end
                    m_flag = 1'b1;
                end
                m_exp = data_b + 32'd1;
            end
            if (TO_EN) begin
                if (vld_b) m_idle = 0;
                else if (m_started && m_rdy) begin
                    m_idle = m_idle + 1;
                    if (m_idle >= TO_CYC) m_timeout = 1'b1;
                end
                if (m_acc) m_started = 1'b1;
            end
            m_on_eff = (cfg_on == 4'd0) ? 1 : int'(cfg_on);
            m_period = m_on_eff + int'(cfg_off);
            case (cfg_mode)
                2'd0: m_rdy = 1'b1;
                2'd1: m_rdy = 1'b0;
                2'd2: m_rdy = ((m_per_k % m_period) < m_on_eff);
                default: m_rdy = m_lfsr[0];
            endcase
            m_per_k = (cfg_mode == 2'd2) ? m_per_k + 1 : 0;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            checkOutput("rdy_b", 32'(rdy_b), 32'(m_rdy));
            checkOutput("beat_cnt", beat_cnt, m_beat);
            checkOutput("err_cnt", 32'(err_cnt), 32'(m_errs));
            checkOutput("err_flag", 32'(err_flag), 32'(m_flag));
            checkOutput("err_exp", err_exp, m_eexp);
            checkOutput("err_got", err_got, m_egot);
            checkOutput("proto_err", 32'(proto_err), 32'(m_proto));
            checkOutput("timeout", 32'(timeout), 32'(m_timeout));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_reset(input logic [1:0] mode, input logic [3:0] on, input logic [3:0] off);
        @(negedge clk);
        rst_n = 1'b0; vld_b = 1'b0; data_b = 32'd0;
        cfg_mode = mode; cfg_on = on; cfg_off = off;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Presents one word and holds it until the sink takes it; returns on the negedge after acceptance.
    task automatic applyStimulus(input logic [31:0] word);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        vld_b = 1'b1;
        data_b = word;
        while (!acc && guard < 64) begin
            acc = rdy_b;
            @(negedge clk);
            guard++;
        end
        if (!acc) checkOutput("accept_wait", 32'(acc), 32'd1);
    endtask

    task automatic send_burst(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) applyStimulus(first + 32'(i));
        vld_b = 1'b0;
    endtask

    task automatic sample_rdy(input int n, output logic [15:0] pat);
        pat = 16'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pat = {pat[14:0], rdy_b};
        end
    endtask

    logic [15:0] pat;

    initial begin
        // Reset values while rst_n is held low
        #2;
        checkOutput("rst_rdy_b", 32'(rdy_b), 32'd0);
        checkOutput("rst_beat_cnt", beat_cnt, 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_proto_err", 32'(proto_err), 32'd0);

        // Mode 0, 0..99 back-to-back
        apply_reset(2'd0, 4'd0, 4'd0);
        send_burst(32'd0, 100);
        checkOutput("m0_beat_cnt", beat_cnt, 32'd100);
        checkOutput("m0_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("m0_err_flag", 32'(err_flag), 32'd0);
        checkOutput("m0_proto_err", 32'(proto_err), 32'd0);

        // Mode 2, on=3 off=2
        apply_reset(2'd2, 4'd3, 4'd2);
        sample_rdy(10, pat);
        checkOutput("m2_pattern", 32'(pat[9:0]), 32'b1110011100);
        send_burst(32'd0, 50);
        checkOutput("m2_beat_cnt", beat_cnt, 32'd50);
        checkOutput("m2_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("m2_proto_err", 32'(proto_err), 32'd0);

        // Mode 2 corner settings: on=0 acts as 1; off=0 skips the low phase
        apply_reset(2'd2, 4'd0, 4'd3);
        sample_rdy(8, pat);
        checkOutput("m2_on0_pattern", 32'(pat[7:0]), 32'b10001000);
        send_burst(32'd0, 10);
        apply_reset(2'd2, 4'd2, 4'd0);
        sample_rdy(4, pat);
        checkOutput("m2_off0_pattern", 32'(pat[3:0]), 32'b1111);

        // Skipped word 7
        apply_reset(2'd0, 4'd0, 4'd0);
        send_burst(32'd0, 7);
        send_burst(32'd8, 13);
        checkOutput("skip_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("skip_err_exp", err_exp, 32'd7);
        checkOutput("skip_err_got", err_got, 32'd8);
        checkOutput("skip_beat_cnt", beat_cnt, 32'd20);

        // Second error keeps the first capture; wrap FFFFFFFF->0 is clean
        apply_reset(2'd0, 4'd0, 4'd0);
        send_burst(32'd0, 3);
        applyStimulus(32'd5);
        applyStimulus(32'hFFFF_FFFF);
        send_burst(32'd0, 2);
        checkOutput("wrap_err_cnt", 32'(err_cnt), 32'd2);
        checkOutput("wrap_err_exp", err_exp, 32'd3);
        checkOutput("wrap_err_got", err_got, 32'd5);
        checkOutput("wrap_beat_cnt", beat_cnt, 32'd7);

        // Valid dropped after a stall
        apply_reset(2'd1, 4'd0, 4'd0);
        vld_b = 1'b1; data_b = 32'd5;
        @(negedge clk);
        vld_b = 1'b0;
        @(negedge clk);
        checkOutput("drop_proto_err", 32'(proto_err), 32'd1);
        checkOutput("drop_beat_cnt", beat_cnt, 32'd0);
        checkOutput("drop_err_cnt", 32'(err_cnt), 32'd0);

        // Data changed 5 -> 6 after a stall
        apply_reset(2'd1, 4'd0, 4'd0);
        vld_b = 1'b1; data_b = 32'd5;
        @(negedge clk);
        data_b = 32'd6;
        @(negedge clk);
        checkOutput("chg_proto_err", 32'(proto_err), 32'd1);
        checkOutput("chg_err_flag", 32'(err_flag), 32'd0);
        vld_b = 1'b0;

        // Mode 3 random backpressure, then mode 1
        apply_reset(2'd3, 4'd0, 4'd0);
        sample_rdy(5, pat);
        checkOutput("m3_first_rdy", 32'(pat[4:0]), 32'b11110);
        send_burst(32'd0, 500);
        cfg_mode = 2'd1;
        @(negedge clk);
        checkOutput("m1_rdy_low", 32'(rdy_b), 32'd0);
        checkOutput("m3_beat_cnt", beat_cnt, 32'd500);
        checkOutput("m3_err_cnt", 32'(err_cnt), 32'd0);

        // Mid-stream asynchronous reset after an error
        cfg_mode = 2'd0;
        @(negedge clk);
        applyStimulus(32'd999);
        checkOutput("pre_rst_err_flag", 32'(err_flag), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_rdy_b", 32'(rdy_b), 32'd0);
        checkOutput("arst_beat_cnt", beat_cnt, 32'd0);
        checkOutput("arst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("arst_err_flag", 32'(err_flag), 32'd0);
        checkOutput("arst_err_exp", err_exp, 32'd0);
        checkOutput("arst_err_got", err_got, 32'd0);
        checkOutput("arst_proto_err", 32'(proto_err), 32'd0);
        checkOutput("arst_timeout", 32'(timeout), 32'd0);
        vld_b = 1'b0;

        // Idle timeout: 16 idle cycles trip it, 15 do not
        apply_reset(2'd0, 4'd0, 4'd0);
        send_burst(32'd0, 1);
        repeat (TO_CYC) @(negedge clk);
        checkOutput("to_16_idle", 32'(timeout), 32'(TO_EN));
        apply_reset(2'd0, 4'd0, 4'd0);
        send_burst(32'd0, 1);
        repeat (TO_CYC - 1) @(negedge clk);
        send_burst(32'd1, 1);
        checkOutput("to_15_idle", 32'(timeout), 32'd0);
        checkOutput("to_beat_cnt", beat_cnt, 32'd2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_sink_chk.md
Name: stream_sink_chk

Overview:
- Synthesizable consumer for the 32-bit valid/ready stream (data_b/vld_b/rdy_b) at the output of the bubble-collapsing pipeline stage.
- Generates programmable backpressure on rdy_b.
- Checks the received data against the source's incrementing sequence and checks handshake-protocol compliance.
- Exposes beat and error counters plus first-error capture for the bench and for on-chip debug.

Parameters:
- WIDTH, 32, data width of data_b.
- START_VAL, 0, first expected data word after reset.
- TIMEOUT_CYC, 256, idle-timeout threshold in cycles (used only with SINK_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_b  in  WIDTH  stream data.
- vld_b  in  1  stream valid.
- rdy_b  out  1  stream ready; registered output.
- cfg_mode  in  2  backpressure mode: 0 always, 1 never, 2 periodic, 3 random.
- cfg_on  in  4  periodic mode: number of ready-high cycles (0 is treated as 1).
- cfg_off  in  4  periodic mode: number of ready-low cycles (0 means no low phase).
- beat_cnt  out  32  count of accepted beats; wraps.
- err_cnt  out  16  data-mismatch count; saturates at 16'hFFFF.
- err_flag  out  1  sticky: at least one data mismatch has occurred.
- err_exp  out  WIDTH  expected value at the first mismatch.
- err_got  out  WIDTH  received value at the first mismatch.
- proto_err  out  1  sticky: handshake rule violated.
- timeout  out  1  sticky idle timeout; tied 0 without SINK_TIMEOUT_EN.

Behaviour:
- Reset values (async, rst_n=0):
  - rdy_b=0, beat_cnt=0, err_cnt=0, err_flag=0, err_exp=0, err_got=0, proto_err=0, timeout=0.
  - Expected value exp=START_VAL; LFSR=16'hACE1; periodic counter=0 in the ON phase.
- Reset mid-operation clears all state immediately. The first rdy_b rises no earlier than the first clk edge after deassertion.
- Accept: a beat is accepted at a rising edge where vld_b&rdy_b=1. Accepted data is consumed in the same cycle; there is no internal buffering and no output data path.
- rdy_b generation: rdy_b is a flop whose next value is computed from the mode.
  - Mode 0: 1.
  - Mode 1: 0.
  - Mode 2: two-phase FSM ON/OFF with a 4-bit counter.
    - ON holds rdy_b=1 for max(cfg_on,1) cycles, then goes to OFF.
    - OFF holds rdy_b=0 for cfg_off cycles, then goes to ON.
    - If cfg_off=0, the FSM skips OFF.
  - Mode 3: 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced every cycle; rdy_b_next = lfsr[0].
  - A cfg_mode change takes effect on the next cycle. The periodic FSM restarts in ON with counter 0 whenever mode 2 is entered.
- Data check, on each accepted beat:
  - beat_cnt += 1 (wrapping).
  - If data_b != exp:
    - err_cnt += 1 (saturating).
    - err_flag <= 1.
    - If err_flag was 0, capture err_exp <= exp and err_got <= data_b.
  - exp <= data_b + 1 (mod 2^WIDTH). This resynchronizes, so a single dropped word costs exactly one error.
  - Wrap from 32'hFFFFFFFF to 0 is legal and is not an error.
- Protocol check: a stalled beat is one where vld_b=1 and rdy_b=0 at an edge. At the next edge, vld_b must still be 1 and data_b must equal the stalled value. Otherwise proto_err <= 1 (sticky). The stalled data is held in a WIDTH-bit register plus a stall flag.
- Simultaneous events: a mismatch and a protocol error in the same cycle set both flags. Counters update once per accepted beat.

Optional Feature:
- Macro SINK_TIMEOUT_EN, when defined:
  - A 16-bit counter counts consecutive cycles with rdy_b=1 and vld_b=0, starting only after the first accepted beat.
  - The counter clears on any vld_b=1.
  - When the count reaches TIMEOUT_CYC, timeout <= 1 (sticky until reset).
- When the macro is undefined: no counter is built, and the timeout port is tied to 0.

Test Plan:
- Mode 0, source sends 0..99 back-to-back -> beat_cnt=100, err_cnt=0, err_flag=0, proto_err=0.
- Mode 2 with cfg_on=3, cfg_off=2 -> rdy_b pattern 1,1,1,0,0 repeating. After 50 beats of 0..49: beat_cnt=50, err_cnt=0.
- Source skips word 7 (sends 0..6, then 8..20) -> err_cnt=1, err_exp=7, err_got=8, beat_cnt=20.
- Source drops vld_b, or changes data from 5 to 6, in the cycle after a stall -> proto_err=1 next cycle; data counters unaffected.
- Mode 3 for 1000 cycles, then mode 1 -> rdy_b matches the LFSR reference model (seed ACE1), then rdy_b=0 one cycle after the switch. Assert rst_n=0 mid-stream -> all outputs return to reset values asynchronously.
- SINK_TIMEOUT_EN with TIMEOUT_CYC=16, mode 0: one beat, then vld_b=0 for 16 cycles -> timeout=1. With only 15 idle cycles before the next beat -> timeout stays 0.
